// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_ctrl
//  Purpose  : MEM-stage data-memory handshake FSM (IDLE/READ/WRITE/DONE) that
//             stalls the pipeline until DMEM_ready. Define LOAD_BUF_EN to
//             compile in a one-entry write-through load buffer.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_access_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead_MEM,
    input  logic        MemWrite_MEM,
    input  logic [31:0] ALU_result_MEM,
    input  logic [31:0] WriteData_MEM,
    output logic        stall_MEM,
    output logic [31:0] Mem_Data_WB,
    output logic        DMEM_read,
    output logic        DMEM_write,
    output logic [29:0] DMEM_addr,
    output logic [31:0] DMEM_wdata,
    input  logic [31:0] DMEM_rdata,
    input  logic        DMEM_ready
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_READ  = 2'd1;
    localparam logic [1:0] c_WRITE = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] mem_data_q, mem_data_d;
    logic [29:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        w_hit;
    logic [31:0] w_hit_data;
    logic        w_rd_done;
    logic        w_wr_done;
    logic        w_unused_addr_lsb;

    assign w_unused_addr_lsb = ^ALU_result_MEM[1:0];
    assign w_rd_done         = (state_q == c_READ)  && DMEM_ready;
    assign w_wr_done         = (state_q == c_WRITE) && DMEM_ready;
    assign Mem_Data_WB       = mem_data_q;

`ifdef LOAD_BUF_EN
    logic        buf_valid_q, buf_valid_d;
    logic [29:0] buf_tag_q, buf_tag_d;
    logic [31:0] buf_data_q, buf_data_d;

    assign w_hit      = (state_q == c_IDLE) && MemRead_MEM && buf_valid_q &&
                        (buf_tag_q == ALU_result_MEM[31:2]);
    assign w_hit_data = buf_data_q;

    // Every completed read refills the entry; a completed store to the
    // buffered word keeps it coherent (write-through).
    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_tag_d   = buf_tag_q;
        buf_data_d  = buf_data_q;
        if (w_rd_done) begin
            buf_valid_d = 1'b1;
            buf_tag_d   = addr_q;
            buf_data_d  = DMEM_rdata;
        end else if (w_wr_done && buf_valid_q && (buf_tag_q == addr_q)) begin
            buf_data_d  = wdata_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid_q <= 1'b0;
            buf_tag_q   <= '0;
            buf_data_q  <= '0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_tag_q   <= buf_tag_d;
            buf_data_q  <= buf_data_d;
        end
    end
`else
    assign w_hit      = 1'b0;
    assign w_hit_data = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= c_IDLE;
            mem_data_q <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            mem_data_q <= mem_data_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE: begin
                if (MemRead_MEM) begin
                    if (!w_hit) state_d = c_READ;
                end else if (MemWrite_MEM) begin
                    state_d = c_WRITE;
                end
            end
            c_READ:  if (DMEM_ready) state_d = c_DONE;
            c_WRITE: if (DMEM_ready) state_d = c_DONE;
            c_DONE:  state_d = c_IDLE;
            default: state_d = c_IDLE;
        endcase
    end

    // Address and store data are captured while idle so the memory sees a
    // stable request for the whole access even if the MEM inputs move.
    always_comb begin
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        mem_data_d = mem_data_q;
        if (state_q == c_IDLE) begin
            addr_d  = ALU_result_MEM[31:2];
            wdata_d = WriteData_MEM;
        end
        if (w_rd_done) begin
            mem_data_d = DMEM_rdata;
        end else if (w_hit) begin
            mem_data_d = w_hit_data;
        end
    end

    always_comb begin
        stall_MEM  = 1'b0;
        DMEM_read  = 1'b0;
        DMEM_write = 1'b0;
        DMEM_addr  = ALU_result_MEM[31:2];
        DMEM_wdata = WriteData_MEM;
        case (state_q)
            c_IDLE: begin
                stall_MEM = MemRead_MEM ? !w_hit : MemWrite_MEM;
            end
            c_READ: begin
                stall_MEM  = 1'b1;
                DMEM_read  = 1'b1;
                DMEM_addr  = addr_q;
                DMEM_wdata = wdata_q;
            end
            c_WRITE: begin
                stall_MEM  = 1'b1;
                DMEM_write = 1'b1;
                DMEM_addr  = addr_q;
                DMEM_wdata = wdata_q;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_access_ctrl
//  Purpose  : Directed per-cycle vector table plus stall/strobe counting
//             sequences for mem_access_ctrl (LOAD_BUF_EN rows when defined).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        MemRead_MEM = 1'b0;
    logic        MemWrite_MEM = 1'b0;
    logic [31:0] ALU_result_MEM = '0;
    logic [31:0] WriteData_MEM = '0;
    logic        stall_MEM;
    logic [31:0] Mem_Data_WB;
    logic        DMEM_read;
    logic        DMEM_write;
    logic [29:0] DMEM_addr;
    logic [31:0] DMEM_wdata;
    logic [31:0] DMEM_rdata = '0;
    logic        DMEM_ready = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        rst, rd, wr;
        logic [31:0] addr, wdata, rdata;
        logic        ready;
        logic        chk;
        logic        stall, dread, dwrite;
        logic [31:0] mdata;
    } vec_t;

    vec_t vecs[80];
    int   n_vec = 0;

    mem_access_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .MemRead_MEM    (MemRead_MEM),
        .MemWrite_MEM   (MemWrite_MEM),
        .ALU_result_MEM (ALU_result_MEM),
        .WriteData_MEM  (WriteData_MEM),
        .stall_MEM      (stall_MEM),
        .Mem_Data_WB    (Mem_Data_WB),
        .DMEM_read      (DMEM_read),
        .DMEM_write     (DMEM_write),
        .DMEM_addr      (DMEM_addr),
        .DMEM_wdata     (DMEM_wdata),
        .DMEM_rdata     (DMEM_rdata),
        .DMEM_ready     (DMEM_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                       input logic rdy, input logic chk,
                       input logic st, input logic dr, input logic dw, input logic [31:0] md);
        vecs[n_vec] = '{rst: r, rd: rd, wr: wr, addr: a, wdata: wd, rdata: rdat,
                        ready: rdy, chk: chk, stall: st, dread: dr, dwrite: dw, mdata: md};
        n_vec++;
    endtask

    // Drives one request, raises DMEM_ready after nwait strobe cycles, and
    // counts stall and strobe cycles until the pipeline is released.
    task automatic seq(input logic is_wr, input logic [31:0] a, input logic [31:0] d,
                       input int nwait, output int ns, output int nst, output logic timeout);
        logic strobe;
        @(negedge clk);
        MemRead_MEM    = !is_wr;
        MemWrite_MEM   = is_wr;
        ALU_result_MEM = a;
        WriteData_MEM  = is_wr ? d : 32'h0;
        DMEM_ready     = 1'b0;
        DMEM_rdata     = '0;
        ns = 0; nst = 0; timeout = 1'b1;
        for (int c = 0; c < 32; c++) begin
            #1;
            if (!stall_MEM) begin
                timeout = 1'b0;
                break;
            end
            ns++;
            strobe = is_wr ? DMEM_write : DMEM_read;
            if (strobe) begin
                nst++;
                check($sformatf("seq addr c%0d", c), {2'b00, DMEM_addr}, {2'b00, a[31:2]});
                if (is_wr) check($sformatf("seq wdata c%0d", c), DMEM_wdata, d);
                if (nst == nwait + 1) begin
                    DMEM_ready = 1'b1;
                    DMEM_rdata = d;
                end
            end
            @(negedge clk);
            DMEM_ready = 1'b0;
            DMEM_rdata = '0;
        end
        MemRead_MEM  = 1'b0;
        MemWrite_MEM = 1'b0;
    endtask

    initial begin
        int       ns, nst;
        logic     to;
        vec_t     v;

        // rst rd wr addr wdata rdata rdy | chk stall rd wr Mem_Data_WB
        add(1,0,0, 32'h0,  32'h0, 32'h0, 0, 0, 0,0,0, 32'h0);
        add(1,0,0, 32'h0,  32'h0, 32'h0, 0, 1, 0,0,0, 32'h0);
        add(0,0,0, 32'h0,  32'h0, 32'h0, 0, 1, 0,0,0, 32'h0);
        add(0,0,0, 32'h0,  32'h0, 32'h0, 0, 1, 0,0,0, 32'h0);
        // load 0x10, ready in third READ cycle
        add(0,1,0, 32'h10, 32'h0, 32'h0, 0, 1, 1,0,0, 32'h0);
        add(0,1,0, 32'h10, 32'h0, 32'h0, 0, 1, 1,1,0, 32'h0);
        add(0,1,0, 32'h10, 32'h0, 32'h0, 0, 1, 1,1,0, 32'h0);
        add(0,1,0, 32'h10, 32'h0, 32'hDEADBEEF, 1, 1, 1,1,0, 32'h0);
        add(0,1,0, 32'h10, 32'h0, 32'h0, 0, 1, 0,0,0, 32'hDEADBEEF);
        add(0,0,0, 32'h0,  32'h0, 32'hFFFFFFFF, 1, 1, 0,0,0, 32'hDEADBEEF);
        add(0,0,0, 32'h0,  32'h0, 32'h0, 0, 1, 0,0,0, 32'hDEADBEEF);
        // store 0x12345678 to 0x20, then load 0x20 at the minimum spacing
        add(0,0,1, 32'h20, 32'h12345678, 32'h0, 0, 1, 1,0,0, 32'hDEADBEEF);
        add(0,0,1, 32'h20, 32'h12345678, 32'h55555555, 1, 1, 1,0,1, 32'hDEADBEEF);
        add(0,0,1, 32'h20, 32'h12345678, 32'h0, 0, 1, 0,0,0, 32'hDEADBEEF);
        add(0,1,0, 32'h20, 32'h0, 32'h0, 0, 1, 1,0,0, 32'hDEADBEEF);
        add(0,1,0, 32'h20, 32'h0, 32'h12345678, 1, 1, 1,1,0, 32'hDEADBEEF);
        add(0,0,0, 32'h20, 32'h0, 32'h0, 0, 1, 0,0,0, 32'h12345678);
        // simultaneous read and write: read wins
        add(0,1,1, 32'h30, 32'hCAFEF00D, 32'h0, 0, 1, 1,0,0, 32'h12345678);
        add(0,1,1, 32'h30, 32'hCAFEF00D, 32'h0, 0, 1, 1,1,0, 32'h12345678);
        add(0,1,1, 32'h30, 32'hCAFEF00D, 32'h0BADF00D, 1, 1, 1,1,0, 32'h12345678);
        add(0,0,0, 32'h30, 32'hCAFEF00D, 32'h0, 0, 1, 0,0,0, 32'h0BADF00D);
        // request withdrawn during READ still completes
        add(0,1,0, 32'h50, 32'h0, 32'h0, 0, 1, 1,0,0, 32'h0BADF00D);
        add(0,0,0, 32'h50, 32'h0, 32'h0, 0, 1, 1,1,0, 32'h0BADF00D);
        add(0,0,0, 32'h50, 32'h0, 32'h11112222, 1, 1, 1,1,0, 32'h0BADF00D);
        add(0,0,0, 32'h50, 32'h0, 32'h0, 0, 1, 0,0,0, 32'h11112222);
        // reset in second READ cycle, late ready ignored, no DONE
        add(0,1,0, 32'h60, 32'h0, 32'h0, 0, 1, 1,0,0, 32'h11112222);
        add(0,1,0, 32'h60, 32'h0, 32'h0, 0, 1, 1,1,0, 32'h11112222);
        add(1,1,0, 32'h60, 32'h0, 32'h0, 0, 1, 1,1,0, 32'h11112222);
        add(0,0,0, 32'h60, 32'h0, 32'h77777777, 1, 1, 0,0,0, 32'h0);
        add(0,1,0, 32'h70, 32'h0, 32'h0, 0, 1, 1,0,0, 32'h0);
        add(0,1,0, 32'h70, 32'h0, 32'h70707070, 1, 1, 1,1,0, 32'h0);
        add(0,0,0, 32'h70, 32'h0, 32'h0, 0, 1, 0,0,0, 32'h70707070);
`ifdef LOAD_BUF_EN
        // fill at 0x40, then hit
        add(0,1,0, 32'h40, 32'h0, 32'h0, 0, 1, 1,0,0, 32'h70707070);
        add(0,1,0, 32'h40, 32'h0, 32'hA5A5A5A5, 1, 1, 1,1,0, 32'h70707070);
        add(0,0,0, 32'h40, 32'h0, 32'h0, 0, 1, 0,0,0, 32'hA5A5A5A5);
        add(0,1,0, 32'h40, 32'h0, 32'hFFFFFFFF, 0, 1, 0,0,0, 32'hA5A5A5A5);
        add(0,0,0, 32'h40, 32'h0, 32'h0, 0, 1, 0,0,0, 32'hA5A5A5A5);
        // write-through store of 1 to 0x40, then hit returns it
        add(0,0,1, 32'h40, 32'h1, 32'h0, 0, 1, 1,0,0, 32'hA5A5A5A5);
        add(0,0,1, 32'h40, 32'h1, 32'h0, 1, 1, 1,0,1, 32'hA5A5A5A5);
        add(0,0,0, 32'h40, 32'h1, 32'h0, 0, 1, 0,0,0, 32'hA5A5A5A5);
        add(0,1,0, 32'h40, 32'h1, 32'h0, 0, 1, 0,0,0, 32'hA5A5A5A5);
        add(0,0,0, 32'h40, 32'h1, 32'h0, 0, 1, 0,0,0, 32'h00000001);
        // reset invalidates the entry
        add(1,0,0, 32'h40, 32'h0, 32'h0, 0, 1, 0,0,0, 32'h00000001);
        add(0,1,0, 32'h40, 32'h0, 32'h0, 0, 1, 1,0,0, 32'h0);
        add(0,1,0, 32'h40, 32'h0, 32'h12121212, 1, 1, 1,1,0, 32'h0);
        add(0,0,0, 32'h40, 32'h0, 32'h0, 0, 1, 0,0,0, 32'h12121212);
`else
        // repeated load always goes to memory
        add(0,1,0, 32'h70, 32'h0, 32'h0, 0, 1, 1,0,0, 32'h70707070);
        add(0,1,0, 32'h70, 32'h0, 32'h0F0F0F0F, 1, 1, 1,1,0, 32'h70707070);
        add(0,0,0, 32'h70, 32'h0, 32'h0, 0, 1, 0,0,0, 32'h0F0F0F0F);
`endif

        for (int i = 0; i < n_vec; i++) begin
            v = vecs[i];
            @(negedge clk);
            rst            = v.rst;
            MemRead_MEM    = v.rd;
            MemWrite_MEM   = v.wr;
            ALU_result_MEM = v.addr;
            WriteData_MEM  = v.wdata;
            DMEM_rdata     = v.rdata;
            DMEM_ready     = v.ready;
            #1;
            if (v.chk) begin
                check($sformatf("row%0d stall_MEM", i),   {31'b0, stall_MEM},  {31'b0, v.stall});
                check($sformatf("row%0d DMEM_read", i),   {31'b0, DMEM_read},  {31'b0, v.dread});
                check($sformatf("row%0d DMEM_write", i),  {31'b0, DMEM_write}, {31'b0, v.dwrite});
                check($sformatf("row%0d DMEM_addr", i),   {2'b00, DMEM_addr},  {2'b00, v.addr[31:2]});
                check($sformatf("row%0d DMEM_wdata", i),  DMEM_wdata,          v.wdata);
                check($sformatf("row%0d Mem_Data_WB", i), Mem_Data_WB,         v.mdata);
            end
        end
        @(negedge clk);
        rst = 1'b0; MemRead_MEM = 1'b0; MemWrite_MEM = 1'b0;
        DMEM_ready = 1'b0; DMEM_rdata = '0;
        ALU_result_MEM = '0; WriteData_MEM = '0;

        // load with two wait cycles: stall 4 cycles, 3 read-strobe cycles
        seq(1'b0, 32'h0000_0010, 32'hDEADBEEF, 2, ns, nst, to);
        check("load timeout", {31'b0, to}, 32'd0);
        check("load stall cycles", ns, 32'd4);
        check("load strobe cycles", nst, 32'd3);
        @(negedge clk); #1;
        check("load result", Mem_Data_WB, 32'hDEADBEEF);

        // store with four wait cycles: strobe and data held until ready
        seq(1'b1, 32'h0000_0084, 32'h9ABCDEF0, 4, ns, nst, to);
        check("store timeout", {31'b0, to}, 32'd0);
        check("store stall cycles", ns, 32'd6);
        check("store strobe cycles", nst, 32'd5);
        @(negedge clk); #1;
        check("store keeps Mem_Data_WB", Mem_Data_WB, 32'hDEADBEEF);
        check("idle after store", {31'b0, stall_MEM | DMEM_write | DMEM_read}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
